block_scheduler: RTL and testbench

- Owns a pool of falling-block slots for the playfield.
- Accepts spawn requests from the pattern/ROM sequencer and advances every live block once per frame.
- Retires blocks that leave the screen (miss) or are struck by a lane key inside the hit window (hit).
- Drives slot positions to the colour mapper and keeps score, miss count and game state for the HUD.

---
 rtl/block_scheduler_pkg.sv | 29 ++
 rtl/block_scheduler_if.sv | 13 +
 rtl/block_scheduler_slot_pick.sv | 30 +++
 rtl/block_scheduler.sv | 172 +++++++++++++++++
 tb/tb_block_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/block_scheduler_pkg.sv
// Shared types and constants for the falling-block scheduler:
// game states, lane index, per-slot record and the lane-to-X mapping.
package block_sched_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    PAUSED = ST_PAUSED,
    OVER   = ST_OVER
  } game_state_t;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic       active;
    lane_t      lane;
    logic [9:0] y;
  } slot_t;

  function automatic logic [9:0] lane_x(input lane_t lane, input int x0, input int pitch);
    return 10'(x0 + int'(lane) * pitch);
  endfunction

endpackage

// File: rtl/block_scheduler_if.sv
// Spawn handshake between the pattern sequencer (master) and the scheduler (slave).
// A block transfers on a rising frame_clk edge where spawn_valid && spawn_ready;
// spawn_ready depends only on registered state, and the master holds lane stable while valid.
interface block_scheduler_if;
  import block_sched_pkg::*;

  logic  spawn_valid;
  lane_t spawn_lane;
  logic  spawn_ready;

  modport master (output spawn_valid, output spawn_lane, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_lane, output spawn_ready);
endinterface

// File: rtl/block_scheduler_slot_pick.sv
// Priority selector: among masked entries returns the largest Y, lowest index on ties.
// With all Y equal it reduces to a lowest-set-bit finder.
module slot_pick #(
  parameter int N  = 8,
  parameter int W  = 10,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [N*W-1:0] y,
  output logic [IW-1:0]  idx,
  output logic           found
);

  logic [W-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    // strict '>' keeps the earlier (lower) index when Y values tie
    for (int i = 0; i < N; i++) begin
      if (mask[i] && (!found || (y[i*W +: W] > best))) begin
        found = 1'b1;
        idx   = IW'(i);
        best  = y[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Falling-block slot pool: spawns, moves, hits and misses blocks once per frame
// and keeps score, miss count and the game state for the HUD.
module block_scheduler
  import block_sched_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int NUM_LANES  = 4,
  parameter int SPAWN_Y    = 0,
  parameter int Y_STEP     = 1,
  parameter int Y_MAX      = 479,
  parameter int HIT_Y_LO   = 440,
  parameter int HIT_Y_HI   = 470,
  parameter int LANE_X0    = 200,
  parameter int LANE_PITCH = 80,
  parameter int MISS_LIMIT = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    pause,
  block_scheduler_if.slave        spawn,
  input  logic [NUM_LANES-1:0]    key_press,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [NUM_SLOTS*10-1:0] slot_x,
  output logic [NUM_SLOTS*10-1:0] slot_y,
  output logic                    hit_pulse,
  output logic [NUM_LANES-1:0]    hit_lanes,
  output logic                    miss_pulse,
  output logic [15:0]             score,
  output logic [7:0]              miss_count,
  output logic [1:0]              game_state
);

  localparam int SW = $clog2(NUM_SLOTS);

  game_state_t          state;
  slot_t                slots [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] cand [NUM_LANES];
  logic [SW-1:0]        win_idx [NUM_LANES];
  logic [NUM_LANES-1:0] win_found;
  logic [NUM_SLOTS-1:0] hit_mask, miss_mask;
  logic [NUM_LANES-1:0] hit_next;
  logic [7:0]           hit_cnt, miss_cnt;
  logic [16:0]          score_sum;
  logic [8:0]           miss_sum;
  logic [15:0]          score_next;
  logic [7:0]           miss_next;
  logic [SW-1:0]        free_idx;
  logic                 free_found;
  logic                 ready;
  logic                 spawn_fire;

  always_comb begin
    slot_active = '0;
    slot_x      = '0;
    slot_y      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_active[i]      = slots[i].active;
      slot_y[i*10 +: 10]  = slots[i].y;
      slot_x[i*10 +: 10]  = lane_x(slots[i].lane, LANE_X0, LANE_PITCH);
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      cand[l] = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
        cand[l][i] = slots[i].active && (slots[i].lane == lane_t'(l)) &&
                     (slots[i].y >= 10'(HIT_Y_LO)) && (slots[i].y <= 10'(HIT_Y_HI));
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    slot_pick #(.N(NUM_SLOTS), .W(10)) u_pick (
      .mask  (cand[l]),
      .y     (slot_y),
      .idx   (win_idx[l]),
      .found (win_found[l])
    );
  end

  slot_pick #(.N(NUM_SLOTS), .W(10)) u_free (
    .mask  (~slot_active),
    .y     ('0),
    .idx   (free_idx),
    .found (free_found)
  );

  always_comb begin
    hit_mask = '0;
    hit_next = '0;
    hit_cnt  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (key_press[l] && win_found[l]) begin
        hit_next[l]          = 1'b1;
        hit_mask[win_idx[l]] = 1'b1;
        hit_cnt              = hit_cnt + 8'd1;
      end
    end
    miss_mask = '0;
    miss_cnt  = '0;
    // 11-bit compare so Y + step cannot wrap below Y_MAX
    for (int i = 0; i < NUM_SLOTS; i++) begin
      miss_mask[i] = slots[i].active && !hit_mask[i] &&
                     (({1'b0, slots[i].y} + 11'(Y_STEP)) > 11'(Y_MAX));
      miss_cnt     = miss_cnt + 8'(miss_mask[i]);
    end
    score_sum  = {1'b0, score} + 17'(hit_cnt);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    miss_sum   = {1'b0, miss_count} + 9'(miss_cnt);
    miss_next  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  assign ready             = (state == RUN) && free_found;
  assign spawn.spawn_ready = ready;
  assign spawn_fire        = spawn.spawn_valid && ready;
  assign game_state        = state;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      score      <= '0;
      miss_count <= '0;
      hit_pulse  <= 1'b0;
      hit_lanes  <= '0;
      miss_pulse <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      hit_lanes  <= '0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state      <= RUN;
            score      <= '0;
            miss_count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
          end
        end
        PAUSED: begin
          if (!pause) state <= RUN;
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (hit_mask[i] || miss_mask[i]) slots[i].active <= 1'b0;
              else if (slots[i].active)        slots[i].y      <= slots[i].y + 10'(Y_STEP);
            end
            score      <= score_next;
            miss_count <= miss_next;
            hit_lanes  <= hit_next;
            hit_pulse  <= |hit_next;
            miss_pulse <= |miss_mask;
            if (miss_next >= 8'(MISS_LIMIT)) state <= OVER;
          end
          // ready was visible this edge, so an offered block is always taken
          if (spawn_fire) begin
            slots[free_idx].active <= 1'b1;
            slots[free_idx].lane   <= spawn.spawn_lane;
            slots[free_idx].y      <= 10'(SPAWN_Y);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: spawn, fall, miss, hit window, pause,
// game over/restart and asynchronous reset, with hand-computed expectations.
module tb_block_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        pause;
  logic [3:0]  key_press;
  logic [7:0]  slot_active;
  logic [79:0] slot_x;
  logic [79:0] slot_y;
  logic        hit_pulse;
  logic [3:0]  hit_lanes;
  logic        miss_pulse;
  logic [15:0] score;
  logic [7:0]  miss_count;
  logic [1:0]  game_state;

  block_scheduler_if sif ();

  block_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .start       (start),
    .pause       (pause),
    .spawn       (sif),
    .key_press   (key_press),
    .slot_active (slot_active),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .hit_pulse   (hit_pulse),
    .hit_lanes   (hit_lanes),
    .miss_pulse  (miss_pulse),
    .score       (score),
    .miss_count  (miss_count),
    .game_state  (game_state)
  );

  // clock/reset
  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic spawn_one(input logic [1:0] lane);
    sif.spawn_valid = 1'b1;
    sif.spawn_lane  = lane;
    tick(1);
    sif.spawn_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] keys);
    key_press = keys;
    tick(1);
    key_press = '0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pause = 1'b0; key_press = '0;
    sif.spawn_valid = 1'b0; sif.spawn_lane = '0;
    tick(2);
    check("rst_state", game_state, 0);
    check("rst_active", slot_active, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss_count, 0);
    check("rst_pulses", {hit_pulse, hit_lanes, miss_pulse}, 0);
    check("rst_y", slot_y, 0);
    Reset = 1'b0;
    tick(1);
    check("idle_hold", game_state, 0);
    check("idle_ready", sif.spawn_ready, 0);

    // first block: spawn, fall to the bottom, miss
    start = 1'b1; tick(1); start = 1'b0;
    check("run_state", game_state, 1);
    check("run_ready", sif.spawn_ready, 1);
    spawn_one(2'd2);
    check("s1_active", slot_active, 8'h01);
    check("s1_y0", slot_y[9:0], 0);
    check("s1_x0", slot_x[9:0], 360);
    tick(479);
    check("s1_y479", slot_y[9:0], 479);
    check("s1_nomiss", miss_pulse, 0);
    tick(1);
    check("s1_cleared", slot_active, 0);
    check("s1_misspulse", miss_pulse, 1);
    check("s1_misscnt", miss_count, 1);
    tick(1);
    check("s1_pulse_end", miss_pulse, 0);

    // two lane-1 blocks ten pixels apart; key takes the lower one
    spawn_one(2'd1);
    tick(9);
    spawn_one(2'd1);
    tick(450);
    check("h_y0", slot_y[9:0], 460);
    check("h_y1", slot_y[19:10], 450);
    press(4'b0010);
    check("h_active", slot_active, 8'h02);
    check("h_score", score, 1);
    check("h_lanes", hit_lanes, 4'b0010);
    check("h_pulse", hit_pulse, 1);
    check("h_y1_moved", slot_y[19:10], 451);
    tick(1);
    check("h_pulse_end", {hit_pulse, hit_lanes}, 0);
    check("h_y1_452", slot_y[19:10], 452);
    press(4'b0010);
    check("h2_score", score, 2);
    check("h2_active", slot_active, 0);

    // lane 3 just above the window: key has no effect
    spawn_one(2'd3);
    check("l3_x", slot_x[9:0], 440);
    tick(439);
    check("l3_y439", slot_y[9:0], 439);
    press(4'b1000);
    check("l3_nohit_score", score, 2);
    check("l3_nohit_pulse", hit_pulse, 0);
    check("l3_y440", slot_y[9:0], 440);
    tick(5);

    // pause with block in the window and key held
    pause = 1'b1; key_press = 4'b1000;
    tick(1);
    check("p_state", game_state, 2);
    check("p_ready", sif.spawn_ready, 0);
    check("p_y_frozen", slot_y[9:0], 445);
    sif.spawn_valid = 1'b1; sif.spawn_lane = 2'd0;
    tick(4);
    check("p_y_still", slot_y[9:0], 445);
    check("p_score", score, 2);
    check("p_nohit", hit_pulse, 0);
    check("p_nospawn", slot_active, 8'h01);
    sif.spawn_valid = 1'b0; pause = 1'b0; key_press = '0;
    tick(1);
    check("p_resume_state", game_state, 1);
    check("p_resume_y", slot_y[9:0], 445);
    tick(1);
    check("p_moving", slot_y[9:0], 446);
    press(4'b1000);
    check("p_hit_score", score, 3);
    check("p_hit_lanes", hit_lanes, 4'b1000);

    // fill the pool, then reuse slot0 only after its miss edge
    for (int k = 0; k < 8; k++) begin
      sif.spawn_valid = 1'b1;
      sif.spawn_lane  = 2'(k);
      tick(1);
    end
    check("f_full", slot_active, 8'hFF);
    check("f_ready", sif.spawn_ready, 0);
    check("f_y0", slot_y[9:0], 7);
    check("f_y7", slot_y[79:70], 0);
    check("f_x1", slot_x[19:10], 280);
    check("f_x3", slot_x[39:30], 440);
    sif.spawn_lane = 2'd2;
    tick(472);
    check("f_y0_479", slot_y[9:0], 479);
    tick(1);
    check("f_miss_active", slot_active, 8'hFE);
    check("f_miss_cnt", miss_count, 2);
    check("f_miss_ready", sif.spawn_ready, 1);
    tick(1);
    sif.spawn_valid = 1'b0;
    check("f_reuse_active", slot_active, 8'hFD);
    check("f_reuse_y0", slot_y[9:0], 0);
    check("f_reuse_x0", slot_x[9:0], 360);
    check("f_reuse_cnt", miss_count, 3);

    // remaining slots miss one per frame
    for (int v = 4; v <= 9; v++) exp_q.push_back(32'(v));
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("cascade_cnt", miss_count, exp_q.pop_front());
    end
    check("c_active", slot_active, 8'h01);
    check("c_y0", slot_y[9:0], 6);
    tick(473);
    check("c_still_run", game_state, 1);
    tick(1);
    check("over_state", game_state, 3);
    check("over_cnt", miss_count, 10);
    check("over_pulse", miss_pulse, 1);
    check("over_ready", sif.spawn_ready, 0);
    sif.spawn_valid = 1'b1;
    tick(1);
    sif.spawn_valid = 1'b0;
    check("over_nospawn", slot_active, 0);
    check("over_pulse_end", miss_pulse, 0);
    check("over_hold", game_state, 3);
    start = 1'b1; tick(1); start = 1'b0;
    check("restart_state", game_state, 1);
    check("restart_score", score, 0);
    check("restart_miss", miss_count, 0);
    check("restart_active", slot_active, 0);

    // asynchronous reset between edges
    spawn_one(2'd1);
    tick(1);
    check("ar_pre_y", slot_y[9:0], 1);
    #2 Reset = 1'b1;
    #1;
    check("ar_state", game_state, 0);
    check("ar_active", slot_active, 0);
    check("ar_y", slot_y[9:0], 0);
    check("ar_x", slot_x[9:0], 200);
    Reset = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
